// File: rtl/icache_refill_server_pkg.sv
// Shared constants and types for the instruction-cache refill responder.
package icache_refill_server_pkg;

  localparam int          XLEN              = 32;
  localparam int          IMEM_SIZE         = 1024;
  localparam int          WORD_ADDR_WIDTH   = 10;
  localparam int          ICACHE_LINE_SIZE  = 16;
  localparam int          ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;
  localparam int          LINE_BEAT_W       = $clog2(ICACHE_LINE_WORDS);
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

  typedef enum logic {RF_IDLE, RF_SEND} refill_state_e;

endpackage

// File: rtl/icache_refill_server_if.sv
// Line-request / beat-response channel between the I-cache miss handler and the refill responder.
interface icache_refill_server_if;
  import icache_refill_server_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [XLEN-1:0]        req_addr;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [XLEN-1:0]        rsp_data;
  logic [LINE_BEAT_W-1:0] rsp_beat;
  logic                   rsp_last;
  logic                   rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err
  );
endinterface

// File: rtl/icache_refill_server_imem_dp_ram.sv
// Instruction RAM: one write port, one synchronous read port with enable, read-before-write.
module imem_dp_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and read register have no reset so this maps onto block RAM;
  // non-blocking writes make a same-cycle read of the written word see the old data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_refill_server.sv
// Accepts one line request and streams the aligned line from instruction RAM as LINE_WORDS beats.
module icache_refill_server
  import icache_refill_server_pkg::*;
#(
  parameter int DEPTH      = IMEM_SIZE,
  parameter int ADDR_W     = WORD_ADDR_WIDTH,
  parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  icache_refill_server_if.slave  bus,
  input  logic                   ld_we,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [XLEN-1:0]        ld_data,
  output logic                   busy
);

  localparam int BEAT_W = LINE_BEAT_W;
  localparam int BASE_W = ADDR_W - BEAT_W;

  refill_state_e     state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              err_q, err_d;

  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [XLEN-1:0]   ram_rdata;

  logic [BASE_W-1:0] req_base;
  logic              req_err;
  logic              last_beat;
  logic              unused_offset_bits;

  assign req_base           = bus.req_addr[ADDR_W+1:BEAT_W+2];
  assign req_err            = |bus.req_addr[XLEN-1:ADDR_W+2];
  assign unused_offset_bits = ^bus.req_addr[BEAT_W+1:0];
  assign last_beat          = (beat_q == BEAT_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    err_d     = err_q;
    ram_re    = 1'b0;
    ram_raddr = {base_q, beat_q};
    unique case (state_q)
      RF_IDLE: begin
        if (bus.req_valid && !rst) begin
          state_d   = RF_SEND;
          base_d    = req_base;
          err_d     = req_err;
          beat_d    = '0;
          ram_re    = !req_err;
          ram_raddr = {req_base, {BEAT_W{1'b0}}};
        end
      end
      RF_SEND: begin
        if (bus.rsp_ready) begin
          if (last_beat) begin
            state_d = RF_IDLE;
            beat_d  = '0;
          end else begin
            beat_d    = beat_q + 1'b1;
            ram_re    = !err_q;
            ram_raddr = {base_q, beat_q + 1'b1};
          end
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Outputs derive from state so an asynchronous reset silences the channel at once.
  assign bus.req_ready = (state_q == RF_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RF_SEND);
  assign bus.rsp_beat  = beat_q;
  assign bus.rsp_last  = (state_q == RF_SEND) && last_beat;
  assign bus.rsp_err   = (state_q == RF_SEND) && err_q;
  assign bus.rsp_data  = ((state_q == RF_SEND) && !err_q) ? ram_rdata : NOP_INSTR;
  assign busy          = (state_q == RF_SEND);

  imem_dp_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (XLEN)
  ) u_ram (
    .clk     (clk),
    .we_i    (ld_we),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_icache_refill_server.sv
// Directed bench for icache_refill_server: line bursts, alignment, backpressure, errors, reset, collision.
module tb_icache_refill_server;
  import icache_refill_server_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       ld_we;
  logic [WORD_ADDR_WIDTH-1:0] ld_addr;
  logic [XLEN-1:0]            ld_data;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  icache_refill_server_if bus ();

  icache_refill_server dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares the full channel view {valid,beat,last,err,busy,req_ready,data} for one beat.
  task automatic expect_beat(input string name, input int b, input logic [31:0] d, input logic e);
    logic [39:0] got, exp;
    got = {bus.rsp_valid, bus.rsp_beat, bus.rsp_last, bus.rsp_err, busy, bus.req_ready, bus.rsp_data};
    exp = {1'b1, 2'(b), (b == 3), e, 1'b1, 1'b0, d};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s beat%0d: got v/beat/last/err/busy/rdy/data=%h expected %h", name, b, got, exp);
    end
  endtask

  task automatic expect_idle(input string name);
    logic [2:0] got;
    got = {bus.rsp_valid, busy, bus.req_ready};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL %s idle: got valid/busy/req_ready=%b expected 001", name, got);
    end
  endtask

  task automatic accept(input string name, input logic [31:0] a);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b expected 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
  endtask

  task automatic burst(input string name, input logic [31:0] a, input logic [31:0] d0, input logic e);
    bus.rsp_ready = 1'b1;
    accept(name, a);
    for (int b = 0; b < 4; b++) begin
      expect_beat(name, b, e ? NOP_INSTR : d0 + 32'(b), e);
      step();
    end
    expect_idle(name);
  endtask

  task automatic test_reset();
    logic [39:0] got;
    got = {bus.rsp_valid, bus.rsp_beat, bus.rsp_last, bus.rsp_err, busy, bus.req_ready, bus.rsp_data};
    checks++;
    if (got !== {1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, NOP_INSTR}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", got, {8'h00, NOP_INSTR});
    end
    rst = 1'b0;
    #1;
    expect_idle("reset_release");
  endtask

  task automatic test_basic();
    burst("basic", 32'h40, 32'hA000_0010, 1'b0);
  endtask

  task automatic test_misaligned();
    burst("misaligned", 32'h4C, 32'hA000_0010, 1'b0);
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b1;
    accept("bp", 32'h80);
    expect_beat("bp", 0, 32'hA000_0020, 1'b0);
    step();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_beat("bp_stall", 1, 32'hA000_0021, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      expect_beat("bp", b, 32'hA000_0020 + 32'(b), 1'b0);
      step();
    end
    expect_idle("bp");
  endtask

  task automatic test_out_of_range();
    burst("oor", 32'h0000_1000, 32'h0, 1'b1);
    burst("after_oor", 32'h0, 32'hA000_0000, 1'b0);
  endtask

  task automatic test_reset_abort();
    logic [8:0] got;
    bus.rsp_ready = 1'b1;
    accept("rst_abort", 32'h40);
    expect_beat("rst_abort", 0, 32'hA000_0010, 1'b0);
    step();
    expect_beat("rst_abort", 1, 32'hA000_0011, 1'b0);
    step();
    expect_beat("rst_abort", 2, 32'hA000_0012, 1'b0);
    rst = 1'b1;
    #1;
    got = {bus.rsp_valid, bus.rsp_beat, bus.rsp_last, bus.rsp_err, busy, bus.req_ready, bus.rsp_data == NOP_INSTR};
    checks++;
    if (got !== 9'b0_00_0_0_0_0_1) begin
      errors++;
      $display("FAIL rst_abort_async: got v/beat/last/err/busy/rdy/nop=%b expected 000000001", got);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    expect_idle("rst_abort_release");
    step();
    expect_idle("rst_abort_no_beats");
  endtask

  task automatic test_collision();
    bus.rsp_ready = 1'b1;
    accept("collide", 32'h40);
    ld_we   = 1'b1;
    ld_addr = 10'd17;
    ld_data = 32'hDEAD_BEEF;
    expect_beat("collide", 0, 32'hA000_0010, 1'b0);
    step();
    ld_we = 1'b0;
    expect_beat("collide", 1, 32'hA000_0011, 1'b0);
    step();
    expect_beat("collide", 2, 32'hA000_0012, 1'b0);
    step();
    expect_beat("collide", 3, 32'hA000_0013, 1'b0);
    step();
    expect_idle("collide");
    accept("collide_new", 32'h40);
    expect_beat("collide_new", 0, 32'hA000_0010, 1'b0);
    step();
    expect_beat("collide_new", 1, 32'hDEAD_BEEF, 1'b0);
    step();
    expect_beat("collide_new", 2, 32'hA000_0012, 1'b0);
    step();
    expect_beat("collide_new", 3, 32'hA000_0013, 1'b0);
    step();
    expect_idle("collide_new");
  endtask

  initial begin
    rst           = 1'b1;
    ld_we         = 1'b0;
    ld_addr       = '0;
    ld_data       = '0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    #1;
    // Preload happens under reset: the RAM must keep its writes regardless.
    for (int i = 0; i < 64; i++) begin
      ld_we   = 1'b1;
      ld_addr = 10'(i);
      ld_data = 32'hA000_0000 + 32'(i);
      step();
    end
    ld_we = 1'b0;
    test_reset();
    test_basic();
    test_misaligned();
    test_backpressure();
    test_out_of_range();
    test_reset_abort();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
